// File: rtl/bus_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_controller_if                                          |
// | Purpose  : CPU-side memory bus between the core and bus_controller.   |
// |            master = CPU core, slave = bus_controller.                 |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface bus_controller_if;
  logic [15:0] address;       // CPU byte address
  logic [31:0] data_in;       // store data, byte-lane replicated
  logic [3:0]  write_mask;    // 0 = write lane, 1 = keep lane
  logic        bus_enable;    // request, held for the whole access
  logic        write_enable;  // 1 = store, 0 = load
  logic [31:0] data_out;      // read data, held until next read completes
  logic        data_ready;    // one-cycle completion pulse
  logic        bus_fault;     // sticky fault flag

  modport master (
    output address, data_in, write_mask, bus_enable, write_enable,
    input  data_out, data_ready, bus_fault
  );

  modport slave (
    input  address, data_in, write_mask, bus_enable, write_enable,
    output data_out, data_ready, bus_fault
  );
endinterface
`default_nettype wire

// File: rtl/bus_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bus_controller                                             |
// | Purpose  : Decodes single CPU bus transactions to RAM, ROM or the     |
// |            peripheral window; read-modify-write for partial RAM       |
// |            stores; data_ready completion pulse.                       |
// | Options  : define BUS_FAULT_EN to enable the sticky bus_fault flag    |
// |            (ROM write or peripheral timeout); otherwise tied to 0.    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bus_controller #(
  parameter int RAM_AW         = 12,
  parameter int ROM_AW         = 12,
  parameter int PERIPH_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  bus_controller_if.slave   bus,
  output logic [RAM_AW-1:0] ram_address,
  output logic [31:0]       ram_wdata,
  output logic              ram_we,
  input  logic [31:0]       ram_rdata,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [31:0]       rom_rdata,
  output logic [7:0]        periph_address,
  output logic [31:0]       periph_wdata,
  output logic              periph_we,
  output logic              periph_re,
  input  logic [31:0]       periph_rdata,
  input  logic              periph_ready
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_WAIT    = 3'd1,
    S_RD_CAPTURE = 3'd2,
    S_RMW_READ   = 3'd3,
    S_RMW_WRITE  = 3'd4,
    S_P_WAIT     = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  // Last counter value of the peripheral wait window (count starts at 0).
  localparam logic [3:0] c_pto_last = 4'(PERIPH_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_we;
  logic        r_armed;
  logic        r_p_first;
  logic [3:0]  r_pcnt;
  logic [31:0] r_data_out;
  logic        w_accept;
  logic        w_p_timeout;
  logic        w_data_ready;
  logic [31:0] w_merged;

  // A held-high bus_enable must produce one transaction: armed gates acceptance.
  assign w_accept    = (r_state == S_IDLE) && bus.bus_enable && r_armed;
  assign w_p_timeout = (r_pcnt == c_pto_last);

  // Latched address drives all address outputs; bits [1:0] never reach memory.
  assign ram_address    = r_addr[RAM_AW+1:2];
  assign rom_address    = r_addr[ROM_AW+1:2];
  assign periph_address = r_addr[7:0];
  assign periph_wdata   = r_wdata;
  assign bus.data_out   = r_data_out;
  assign bus.data_ready = w_data_ready;

  // Store merge: a set mask bit keeps the byte currently held in RAM.
  always_comb begin
    w_merged = r_wdata;
    for (int i = 0; i < 4; i++) begin
      if (r_mask[i]) w_merged[8*i +: 8] = ram_rdata[8*i +: 8];
    end
  end

  // Next-state decode and state-derived strobes (drop at once on reset).
  always_comb begin
    w_next_state = r_state;
    ram_we       = 1'b0;
    ram_wdata    = '0;
    periph_we    = 1'b0;
    periph_re    = 1'b0;
    w_data_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.address[15])              w_next_state = S_P_WAIT;
          else if (!bus.write_enable)       w_next_state = S_RD_WAIT;
          else if (bus.address[14])         w_next_state = S_DONE;       // ROM write
          else if (&bus.write_mask)         w_next_state = S_DONE;       // nothing to write
          else if (bus.write_mask == 4'h0)  w_next_state = S_RMW_WRITE;  // full word
          else                              w_next_state = S_RMW_READ;   // partial word
        end
      end
      S_RD_WAIT:    w_next_state = S_RD_CAPTURE;
      S_RD_CAPTURE: w_next_state = S_DONE;
      S_RMW_READ:   w_next_state = S_RMW_WRITE;
      S_RMW_WRITE: begin
        ram_we       = 1'b1;
        ram_wdata    = w_merged;
        w_next_state = S_DONE;
      end
      S_P_WAIT: begin
        periph_we = r_p_first &  r_we;
        periph_re = r_p_first & ~r_we;
        if (periph_ready || w_p_timeout) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_data_ready = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Request capture and re-arm on any cycle with bus_enable low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_we      <= 1'b0;
      r_armed   <= 1'b1;
      r_p_first <= 1'b0;
    end else begin
      r_p_first <= w_accept;
      if (!bus.bus_enable) r_armed <= 1'b1;
      else if (w_accept)   r_armed <= 1'b0;
      if (w_accept) begin
        r_addr  <= bus.address;
        r_wdata <= bus.data_in;
        r_mask  <= bus.write_mask;
        r_we    <= bus.write_enable;
      end
    end
  end

  // Peripheral wait-cycle counter, cleared outside the wait state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_pcnt <= '0;
    else if (r_state == S_P_WAIT) r_pcnt <= r_pcnt + 4'd1;
    else                          r_pcnt <= '0;
  end

  // Read data capture; a timed-out peripheral read returns zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out <= '0;
    end else if (r_state == S_RD_CAPTURE) begin
      r_data_out <= r_addr[14] ? rom_rdata : ram_rdata;
    end else if ((r_state == S_P_WAIT) && !r_we) begin
      if (periph_ready)     r_data_out <= periph_rdata;
      else if (w_p_timeout) r_data_out <= '0;
    end
  end

`ifdef BUS_FAULT_EN
  logic r_fault;

  // Sticky fault on a ROM store or a peripheral that never answered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fault <= 1'b0;
    end else if ((w_accept && bus.write_enable && (bus.address[15:14] == 2'b01)) ||
                 ((r_state == S_P_WAIT) && !periph_ready && w_p_timeout)) begin
      r_fault <= 1'b1;
    end
  end

  assign bus.bus_fault = r_fault;
`else
  assign bus.bus_fault = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bus_controller                                          |
// | Purpose  : Self-checking bench for bus_controller: directed cases     |
// |            plus randomized transactions against a reference model.    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_bus_controller;
  localparam int RAM_AW = 12;
  localparam int ROM_AW = 12;
  localparam int PTO    = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [RAM_AW-1:0] ram_address;
  logic [31:0]       ram_wdata;
  logic              ram_we;
  logic [31:0]       ram_rdata;
  logic [ROM_AW-1:0] rom_address;
  logic [31:0]       rom_rdata;
  logic [7:0]        periph_address;
  logic [31:0]       periph_wdata;
  logic              periph_we;
  logic              periph_re;
  logic [31:0]       periph_rdata;
  logic              periph_ready;

  bus_controller_if bus ();

  bus_controller #(.RAM_AW(RAM_AW), .ROM_AW(ROM_AW), .PERIPH_TIMEOUT(PTO)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .rom_address(rom_address), .rom_rdata(rom_rdata),
    .periph_address(periph_address), .periph_wdata(periph_wdata),
    .periph_we(periph_we), .periph_re(periph_re),
    .periph_rdata(periph_rdata), .periph_ready(periph_ready)
  );

  always #5 clk = ~clk;

  // Synchronous memories as the real macros behave (1-cycle read latency).
  logic [31:0] ram_mem [0:4095];
  logic [31:0] rom_mem [0:4095];
  logic [31:0] ref_ram [0:4095];

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address] <= ram_wdata;
    ram_rdata <= ram_mem[ram_address];
    rom_rdata <= rom_mem[rom_address];
  end

  // Strobe monitor, sampled mid-cycle.
  int          we_cnt = 0, re_cnt = 0, pw_cnt = 0;
  logic [31:0] we_data, pw_data;
  logic [11:0] we_addr;
  logic [7:0]  p_addr;

  always @(negedge clk) begin
    if (ram_we)    begin we_cnt <= we_cnt + 1; we_data <= ram_wdata; we_addr <= ram_address; end
    if (periph_re) begin re_cnt <= re_cnt + 1; p_addr <= periph_address; end
    if (periph_we) begin pw_cnt <= pw_cnt + 1; p_addr <= periph_address; pw_data <= periph_wdata; end
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_dout;
  logic        exp_fault;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU transaction; expectations come from the address map and store rules.
  task automatic run_txn(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic w, input int plat, input int hold, input bit drop);
    int          idx, exp_lat, exp_pulses, k, extra, we0, re0, pw0;
    bit          seen;
    logic [31:0] old_word, merged, rdata_p;
    idx      = int'(a[13:2]);
    old_word = ref_ram[idx];
    merged   = d;
    for (int i = 0; i < 4; i++) if (m[i]) merged[8*i +: 8] = old_word[8*i +: 8];
    rdata_p  = $urandom;
    exp_pulses = 0;
    if (a[15])              exp_lat = (plat <= PTO) ? plat + 1 : PTO + 1;
    else if (!w)            exp_lat = 3;
    else if (a[14])         exp_lat = 1;
    else if (m == 4'hF)     exp_lat = 1;
    else if (m == 4'h0)     begin exp_lat = 2; exp_pulses = 1; end
    else                    begin exp_lat = 3; exp_pulses = 1; end
    if (!w) begin
      if (a[15])      exp_dout = (plat <= PTO) ? rdata_p : 32'h0;
      else if (a[14]) exp_dout = rom_mem[idx];
      else            exp_dout = old_word;
    end
`ifdef BUS_FAULT_EN
    if (w && a[15:14] == 2'b01) exp_fault = 1'b1;
    if (a[15] && plat > PTO)    exp_fault = 1'b1;
`endif
    we0 = we_cnt; re0 = re_cnt; pw0 = pw_cnt;
    @(negedge clk);
    bus.address = a; bus.data_in = d; bus.write_mask = m;
    bus.write_enable = w; bus.bus_enable = 1'b1;
    periph_rdata = rdata_p;
    seen = 0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.data_ready) begin
        seen = 1;
        periph_ready = 1'b0;
      end else begin
        if (drop && k == 1) bus.bus_enable = 1'b0;
        periph_ready = a[15] && (k >= plat);
      end
    end
    check("latency", k, exp_lat);
    @(negedge clk);
    check("ready_pulse", {31'b0, bus.data_ready}, 32'h0);
    extra = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.data_ready) extra++;
    end
    if (hold > 0) check("held_single", extra, 0);
    bus.bus_enable = 1'b0;
    if (exp_pulses == 1) ref_ram[idx] = merged;
    check("data_out", bus.data_out, exp_dout);
    check("ram_we_pulses", we_cnt - we0, exp_pulses);
    if (exp_pulses == 1) begin
      check("ram_wdata", we_data, merged);
      check("ram_waddr", {20'b0, we_addr}, idx);
    end
    if (a[15]) begin
      check("periph_strobes", {pw_cnt - pw0, re_cnt - re0}, w ? {32'd1, 32'd0} : {32'd0, 32'd1});
      check("periph_addr", {24'b0, p_addr}, {24'b0, a[7:0]});
      if (w) check("periph_wdata", pw_data, d);
    end
    if (a[15:14] == 2'b01) check("rom_address", {20'b0, rom_address}, idx);
    check("bus_fault", {31'b0, bus.bus_fault}, {31'b0, exp_fault});
  endtask

  task automatic reset_mid_rmw();
    int we0;
    we0 = we_cnt;
    @(negedge clk);
    bus.address = 16'h0010; bus.data_in = $urandom; bus.write_mask = 4'b0110;
    bus.write_enable = 1'b1; bus.bus_enable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_ram_we", {31'b0, ram_we}, 32'h0);
    check("rst_ready", {31'b0, bus.data_ready}, 32'h0);
    bus.bus_enable = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_no_write", we_cnt - we0, 0);
    check("rst_data_out", bus.data_out, 32'h0);
    reset = 1'b0;
    exp_dout  = 32'h0;
    exp_fault = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [3:0]  m;
    for (int i = 0; i < 4096; i++) begin
      ram_mem[i] = $urandom;
      ref_ram[i] = ram_mem[i];
      rom_mem[i] = $urandom;
    end
    rom_mem[2] = 32'hDEADBEEF;
    bus.address = '0; bus.data_in = '0; bus.write_mask = '0;
    bus.write_enable = 1'b0; bus.bus_enable = 1'b0;
    periph_ready = 1'b0; periph_rdata = '0;
    exp_dout = 32'h0; exp_fault = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_data_out", bus.data_out, 32'h0);
    check("rst_outputs", {bus.data_ready, bus.bus_fault, ram_we, periph_we, periph_re}, 32'h0);
    check("rst_addr", {ram_address, periph_address}, 32'h0);
    check("rst_wdata", ram_wdata | periph_wdata, 32'h0);
    reset = 1'b0;

    run_txn(16'h4008, 32'h0, 4'h0, 1'b0, 1, 0, 0);          // ROM read
    run_txn(16'h0010, 32'h12345678, 4'h0, 1'b1, 1, 0, 0);   // full RAM store
    run_txn(16'h0010, 32'h0, 4'h0, 1'b0, 1, 0, 0);          // readback
    run_txn(16'h0011, 32'hAAAAAAAA, 4'b1101, 1'b1, 1, 0, 0);// byte store
    check("byte_merge", we_data, 32'h1234AA78);
    run_txn(16'h4008, 32'h0, 4'h0, 1'b0, 1, 10, 0);         // held enable
    run_txn(16'h0010, 32'h0, 4'h0, 1'b0, 1, 0, 0);          // re-accept after drop
    run_txn(16'h8004, 32'h0, 4'h0, 1'b0, 99, 0, 0);         // peripheral timeout
    run_txn(16'h4020, 32'h55, 4'h0, 1'b1, 1, 0, 0);         // ROM write
    run_txn(16'h0014, 32'hCAFEF00D, 4'hF, 1'b1, 1, 0, 0);   // mask 1111
    run_txn(16'h9A3C, 32'h0BADF00D, 4'h0, 1'b1, 4, 0, 0);   // peripheral write
    reset_mid_rmw();
    run_txn(16'h0010, 32'h0, 4'h0, 1'b0, 1, 0, 0);          // word untouched by abort
    run_txn(16'h0018, 32'h0, 4'h0, 1'b0, 1, 0, 1);          // enable drop mid-read

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 2))
        0:       a = {2'b00, 12'($urandom_range(0, 15)), 2'($urandom)};
        1:       a = {2'b01, 12'($urandom), 2'($urandom)};
        default: a = {1'b1, 15'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0:       m = 4'h0;
        1:       m = 4'hF;
        default: m = 4'($urandom);
      endcase
      run_txn(a, $urandom, m, 1'($urandom), $urandom_range(1, 20), 0, ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/bus_controller.md
Name: bus_controller

Overview:
- Sits directly downstream of the CPU core's memory bus port.
- Accepts one CPU transaction at a time: 16-bit byte address, 32-bit data, active-low byte write mask, bus_enable, write_enable.
- Decodes each transaction to RAM, ROM or the peripheral window.
- Performs read-modify-write for partial stores, because the RAM macro has no byte enables.
- Returns read data with a data_ready handshake.

Parameters:
- RAM_AW, 12, RAM word-address width (4096 x 32 = 16 KB).
- ROM_AW, 12, ROM word-address width.
- PERIPH_TIMEOUT, 15, max cycles to wait for periph_ready before forcing completion.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  16  CPU byte address.
- data_in  input  32  CPU store data, byte-lane replicated by the CPU.
- write_mask  input  4  per-byte mask; 0 = write that lane, 1 = keep.
- bus_enable  input  1  CPU request; held high for the whole request.
- write_enable  input  1  1 = store, 0 = load.
- data_out  output  32  read data, held until the next read completes.
- data_ready  output  1  one-cycle completion pulse.
- bus_fault  output  1  sticky fault flag (see Optional Feature).
- ram_address  output  RAM_AW  RAM word address.
- ram_wdata  output  32  RAM write data.
- ram_we  output  1  RAM write strobe.
- ram_rdata  input  32  RAM read data, valid 1 cycle after the address.
- rom_address  output  ROM_AW  ROM word address.
- rom_rdata  input  32  ROM read data, 1-cycle latency.
- periph_address  output  8  peripheral register byte offset (address[7:0]).
- periph_wdata  output  32  peripheral write data.
- periph_we  output  1  peripheral write strobe.
- periph_re  output  1  peripheral read strobe.
- periph_rdata  input  32  peripheral read data.
- periph_ready  input  1  peripheral completion.

Behaviour:
- Reset (async): state IDLE. All outputs are 0: data_out, data_ready, bus_fault, ram_we, periph_we, periph_re and all address/wdata outputs. armed=1.
- Decode on address[15:14]:
  - 00 = RAM, word index address[RAM_AW+1:2].
  - 01 = ROM, word index address[ROM_AW+1:2].
  - 1x = peripheral.
  - address[1:0] are ignored; alignment is the CPU's job.
- Acceptance: in IDLE, a rising edge with bus_enable=1 and armed=1 latches address, data_in, write_mask and write_enable, then clears armed. armed is set again on any edge where bus_enable=0. This makes a held-high bus_enable produce exactly one transaction.
- States: IDLE, RD_WAIT, RD_CAPTURE, RMW_READ, RMW_WRITE, P_WAIT, DONE.
- RAM/ROM read: IDLE -> RD_WAIT (address driven) -> RD_CAPTURE (latch ram_rdata/rom_rdata into data_out) -> DONE. data_ready is high in DONE, i.e. the 3rd cycle after the acceptance edge.
- RAM full-word write (mask 0000): IDLE -> RMW_WRITE with ram_we=1 for exactly one cycle, ram_wdata=data_in -> DONE.
- RAM partial write (any mask bit 1, at least one bit 0): IDLE -> RMW_READ -> RMW_WRITE -> DONE.
  - Merged lane i = mask[i] ? ram_rdata[8i+7:8i] : data_in[8i+7:8i].
  - ram_we is asserted only in RMW_WRITE.
- Write with mask 1111: no RAM write; goes straight to DONE.
- ROM write: no memory activity; goes to DONE (fault per Optional Feature).
- Peripheral access:
  - periph_we or periph_re is asserted for exactly the first cycle in P_WAIT.
  - Stay in P_WAIT until periph_ready=1, then latch periph_rdata (reads only) -> DONE.
  - A 4-bit cycle counter forces DONE after PERIPH_TIMEOUT cycles. On timeout, a read returns data_out=32'h0000_0000.
- DONE: data_ready=1 for one cycle, then IDLE. Writes leave data_out unchanged.
- Reset asserted mid-transaction: immediate abort. ram_we, periph_we and periph_re drop asynchronously; a partial RMW write is never issued.
- A bus_enable drop mid-transaction is ignored; the transaction completes.

Optional Feature:
- Macro BUS_FAULT_EN.
- Defined: bus_fault goes to 1 on a ROM write or a peripheral timeout, and stays 1 until reset.
- Undefined: bus_fault is tied to 0. ROM writes and timeouts complete silently.

Test Plan:
- Read ROM: address 0x4008 with rom word 2 = 0xDEADBEEF -> rom_address=2; data_ready on the 3rd edge after acceptance; data_out=0xDEADBEEF.
- Full RAM store: address 0x0010, data 0x12345678, mask 0000 -> one ram_we pulse at word 4 with wdata 0x12345678; readback gives 0x12345678.
- Byte store: RAM word 4 = 0x12345678, address 0x0011, data 0xAAAAAAAA, mask 1101 -> ram_wdata=0x1234AA78 with a single ram_we pulse; data_ready 3 cycles after acceptance.
- Held enable: bus_enable held high for 10 cycles on a read -> exactly one data_ready pulse; a second transaction starts only after bus_enable goes low then high.
- Peripheral timeout: read 0x8004 with periph_ready stuck at 0 -> one periph_re pulse; data_ready after PERIPH_TIMEOUT cycles; data_out=0. With BUS_FAULT_EN defined, bus_fault=1.
- Reset during RMW_READ: assert reset -> ram_we never pulses, state returns to IDLE, data_ready=0.
